gs232c_pipe_iq: RTL
===================

# gs232c_pipe_iq

Instruction queue at the consumer end of the fetch-stage handshake. It accepts fetch groups from the PC/fetch stage: `fe_valid`/`fe_cur`/`fe_hint` from the fetch stage, instruction words from the instruction SRAM, and `fe_go` back to the fetch stage. It splits each 16-byte group into per-instruction entries in a circular buffer and presents up to two instructions per cycle to decode. On a pipeline flush it also generates `iq_cancel` back to the fetch stage.

## Interface
- DEPTH, 8, number of queue entries; power of two, ≥ 4
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- fe_valid  in  1  fetch group present
- fe_cur  in  32  byte address of the first valid instruction in the group
- fe_hint  in  16  predictor hint, 4 bits per slot; slot *s* uses bits [4s+3:4s]
- inst_rdata  in  128  four words of the 16-byte block containing `fe_cur`; word *s* is bits [32s+31:32s]; valid whenever `fe_valid`=1
- fe_go  out  1  group accepted this cycle
- flush  in  1  redirect from branch/writeback; empties the queue
- iq_cancel  out  1  invalidates the fetch-stage group; equals `flush`
- de_valid  out  2  bit0: head entry valid; bit1: head+1 valid (only when bit0=1)
- de_pc0, de_pc1  out  32  PCs of head and head+1
- de_inst0, de_inst1  out  32  instruction words of head and head+1
- de_hint0, de_hint1  out  4  hint slices of head and head+1
- de_pop  in  2  number of entries consumed this cycle: 0, 1 or 2; must not exceed popcount(`de_valid`)
- iq_count  out  log2(DEPTH)+1  current occupancy

## Operation
- **Storage:** DEPTH entries, each holding {pc[31:2], inst[31:0], hint[3:0]}. Read pointer `rp`, write pointer `wp` and `iq_count` are each log2(DEPTH)+1 bits; the low bits index the buffer and wrap modulo DEPTH.
- **Accept:** `fe_go = fe_valid & ~flush & (iq_count ≤ DEPTH-4)`.
  - The check uses occupancy at the start of the cycle; entries freed by a same-cycle `de_pop` do not count.
- **Enqueue on `fe_go`:**
  - Slots *s* = `fe_cur[3:2]` … 3 are written in ascending order at `wp`, `wp+1`, ….
  - Entry PC = {`fe_cur[31:4]`, *s*, 2'b00}.
  - `n_push = 4 - fe_cur[3:2]`, i.e. 1 to 4 entries.
- **Dequeue:** `rp += de_pop`. Outputs are combinational reads at `rp` and `rp+1`.
  - `de_valid[0] = (iq_count ≥ 1)`.
  - `de_valid[1] = (iq_count ≥ 2)`.
  - Invalid lanes drive PC, instruction and hint outputs as 0.
- **Count update:** `iq_count_next = iq_count + n_push·fe_go - de_pop`. Push and pop in the same cycle are allowed.
- **Flush:**
  - `rp`, `wp` and `iq_count` are cleared next cycle; `fe_go`=0 that cycle.
  - `de_pop` is ignored that cycle.
  - `iq_cancel`=1 combinationally in the same cycle.
- **Priority:** reset > flush > push/pop.
- **Illegal input:** `de_pop` greater than the valid count is a protocol violation. The block does not guard it; assertion-checked in verification.

## Timing
- **Reset values:**
  - `rp`, `wp`, `iq_count` = 0.
  - `de_valid` = 2'b00; all `de_*` data outputs = 0.
  - `fe_go` = 0 (from `fe_valid` gating) and `iq_cancel` = 0 while inputs are low.
- **Latency:** an entry written in cycle T is visible at `de_*` in T+1. There is no same-cycle bypass.
- **`fe_go`:** purely combinational from `fe_valid`, `flush` and registered `iq_count`. There is no combinational path from `de_pop` to `fe_go`.
- **Full:** `iq_count` > DEPTH-4 holds `fe_go`=0. The fetch stage keeps `fe_valid` and its group stable until `fe_go`.
- **Empty:** `de_valid`=00 and `de_pop` must be 0.
- **Wrap-around:** a group may straddle the end of the buffer; indices wrap modulo DEPTH.
- **Reset mid-operation:** contents are discarded and all pointers return to 0.

## Configuration
- **`GS232C_IQ_HINT_EN`**
  - Defined: entries store the 4-bit `fe_hint` slice for their slot, and `de_hint0`/`de_hint1` drive it.
  - Undefined: hint storage is not built and `de_hint0`/`de_hint1` are tied to 0.

## Test plan
- **Aligned fill:** reset, then `fe_valid`=1, `fe_cur`=0x1c000000, words A/B/C/D.
  - Same cycle: `fe_go`=1.
  - Next cycle: `iq_count`=4, `de_valid`=11, `de_pc0`=0x1c000000/`de_inst0`=A, `de_pc1`=0x1c000004/`de_inst1`=B.
- **Misaligned group:** `fe_cur`=0x1c000008 into an empty queue.
  - Next cycle: `iq_count`=2, `de_pc0`=0x1c000008/C, `de_pc1`=0x1c00000c/D.
- **Backpressure (DEPTH=8):**
  - At `iq_count`=5 with `fe_valid`=1 and `de_pop`=1: `fe_go`=0.
  - Next cycle, `iq_count`=4: `fe_go`=1, then `iq_count`=8 after an aligned push with `de_pop`=0.
- **Flush:** at `iq_count`=6, with `fe_valid`=1 and `de_pop`=2, assert `flush`.
  - Same cycle: `iq_cancel`=1, `fe_go`=0.
  - Next cycle: `iq_count`=0, `de_valid`=00.
- **Wrap-around:** 20 sequential aligned groups from 0x1c000000, with `de_pop`=2 every cycle the queue holds ≥ 2 entries.
  - Decode sees PCs strictly incrementing by 4 with matching words; no loss or duplication across pointer wrap.
- **Hint:** `fe_hint`=0xA5C3 at 0x1c000000.
  - With `GS232C_IQ_HINT_EN` defined: `de_hint0`=0x3, `de_hint1`=0xC.
  - Without it: both 0.

Source files
------------

// File: rtl/gs232c_pipe_iq.sv
// Instruction queue between fetch and decode: splits 16-byte fetch groups into
// per-instruction entries and presents up to two per cycle. Optional hint storage: GS232C_IQ_HINT_EN.
module gs232c_pipe_iq #(
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       fe_valid,
   input  logic [31:0]                fe_cur,
   input  logic [15:0]                fe_hint,
   input  logic [127:0]               inst_rdata,
   output logic                       fe_go,
   input  logic                       flush,
   output logic                       iq_cancel,
   output logic [1:0]                 de_valid,
   output logic [31:0]                de_pc0,
   output logic [31:0]                de_pc1,
   output logic [31:0]                de_inst0,
   output logic [31:0]                de_inst1,
   output logic [3:0]                 de_hint0,
   output logic [3:0]                 de_hint1,
   input  logic [1:0]                 de_pop,
   output logic [$clog2(DEPTH):0]     iq_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ACCEPT_LIM = (AW+1)'(DEPTH - 4);

   logic [AW:0]    rp, wp, count;
   logic [AW:0]    n_push, push_amt, pop_amt;
   logic [AW-1:0]  wr_idx [4];
   logic [AW-1:0]  rd0, rd1;
   logic           v0, v1;

   logic [29:0]    pc_mem   [DEPTH];
   logic [31:0]    inst_mem [DEPTH];

   assign fe_go     = fe_valid & ~flush & (count <= ACCEPT_LIM);
   assign iq_cancel = flush;
   assign iq_count  = count;

   assign n_push   = (AW+1)'(3'd4 - {1'b0, fe_cur[3:2]});
   assign push_amt = fe_go ? n_push : '0;
   assign pop_amt  = (AW+1)'(de_pop);

   // Slot s lands s - start entries past wp; AW-bit arithmetic gives the wrap.
   always_comb begin
      for (int unsigned s = 0; s < 4; s++) begin
         wr_idx[2'(s)] = wp[AW-1:0] + AW'(s) - AW'(fe_cur[3:2]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else if (flush) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else begin
         wp    <= wp + push_amt;
         rp    <= rp + pop_amt;
         count <= count + push_amt - pop_amt;
      end
   end

   always_ff @(posedge clock) begin
      if (fe_go) begin
         for (int unsigned s = 0; s < 4; s++) begin
            if (2'(s) >= fe_cur[3:2]) begin
               pc_mem[wr_idx[2'(s)]]   <= {fe_cur[31:4], 2'(s)};
               inst_mem[wr_idx[2'(s)]] <= inst_rdata[32*s +: 32];
            end
         end
      end
   end

   assign rd0 = rp[AW-1:0];
   assign rd1 = rd0 + AW'(1);
   assign v0  = (count != '0);
   assign v1  = (count > (AW+1)'(1));

   assign de_valid = {v1, v0};
   assign de_pc0   = v0 ? {pc_mem[rd0], 2'b00} : '0;
   assign de_pc1   = v1 ? {pc_mem[rd1], 2'b00} : '0;
   assign de_inst0 = v0 ? inst_mem[rd0] : '0;
   assign de_inst1 = v1 ? inst_mem[rd1] : '0;

`ifdef GS232C_IQ_HINT_EN
   logic [3:0] hint_mem [DEPTH];
   logic       unused_bits;

   always_ff @(posedge clock) begin
      if (fe_go) begin
         for (int unsigned s = 0; s < 4; s++) begin
            if (2'(s) >= fe_cur[3:2]) begin
               hint_mem[wr_idx[2'(s)]] <= fe_hint[4*s +: 4];
            end
         end
      end
   end

   assign de_hint0    = v0 ? hint_mem[rd0] : '0;
   assign de_hint1    = v1 ? hint_mem[rd1] : '0;
   assign unused_bits = ^fe_cur[1:0];
`else
   logic unused_bits;

   assign de_hint0    = '0;
   assign de_hint1    = '0;
   assign unused_bits = ^{fe_cur[1:0], fe_hint};
`endif

endmodule
